// File: rtl/cfg_cmd_scheduler.sv
// Round-robin scheduler sharing one command executor between the N64 config
// path and the host/USB path, with issue handshake, timeout and result return.
module cfg_cmd_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        n64_pending,
   input  logic [7:0]  n64_cmd,
   input  logic [31:0] n64_arg0,
   input  logic [31:0] n64_arg1,
   output logic        n64_done,
   output logic        n64_error,
   output logic [31:0] n64_result0,
   output logic [31:0] n64_result1,

   input  logic        host_valid,
   input  logic [7:0]  host_cmd,
   input  logic [31:0] host_arg0,
   input  logic [31:0] host_arg1,
   output logic        host_ready,
   output logic        host_done,
   output logic        host_error,
   output logic [31:0] host_result0,
   output logic [31:0] host_result1,

   output logic        exec_valid,
   output logic        exec_src,
   output logic [7:0]  exec_cmd,
   output logic [31:0] exec_arg0,
   output logic [31:0] exec_arg1,
   input  logic        exec_ready,
   input  logic        exec_done,
   input  logic        exec_error,
   input  logic [31:0] exec_result0,
   input  logic [31:0] exec_result1,
   output logic        exec_abort,
   output logic        busy
);

   localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic           SRC_N64  = 1'b0;
   localparam logic           SRC_HOST = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COMPLETE
   } state_t;

   state_t        state;
   logic          last_grant;
   logic [CW-1:0] count;

   logic          grant_n64;
   logic          grant_host;
   logic          done_win;
   logic          timeout;
   logic          finish;
   logic          fin_error;
   logic [31:0]   fin_result0;
   logic [31:0]   fin_result1;

   // NOTE: host_ready and exec_abort are decoded combinationally so the accept
   // lands in the grant cycle and the abort can yield to a same-cycle exec_done.
   always_comb begin
      grant_host  = !reset && (state == S_IDLE) && host_valid
                    && (!n64_pending || (last_grant == SRC_N64));
      grant_n64   = !reset && (state == S_IDLE) && n64_pending
                    && (!host_valid || (last_grant == SRC_HOST));
      done_win    = (state == S_WAIT) && exec_done;
      timeout     = !reset && ((state == S_ISSUE) || (state == S_WAIT))
                    && (count == LAST) && !done_win;
      finish      = done_win || timeout;
      fin_error   = done_win ? exec_error   : 1'b1;
      fin_result0 = done_win ? exec_result0 : 32'h0;
      fin_result1 = done_win ? exec_result1 : 32'h0;
   end

   assign host_ready = grant_host;
   assign exec_abort = timeout;
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         last_grant   <= SRC_HOST;
         count        <= '0;
         exec_valid   <= 1'b0;
         exec_src     <= SRC_N64;
         exec_cmd     <= '0;
         exec_arg0    <= '0;
         exec_arg1    <= '0;
         n64_done     <= 1'b0;
         n64_error    <= 1'b0;
         n64_result0  <= '0;
         n64_result1  <= '0;
         host_done    <= 1'b0;
         host_error   <= 1'b0;
         host_result0 <= '0;
         host_result1 <= '0;
      end else begin
         n64_done  <= 1'b0;
         host_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (grant_n64 || grant_host) begin
                  exec_src   <= grant_host;
                  exec_cmd   <= grant_host ? host_cmd  : n64_cmd;
                  exec_arg0  <= grant_host ? host_arg0 : n64_arg0;
                  exec_arg1  <= grant_host ? host_arg1 : n64_arg1;
                  last_grant <= grant_host;
                  count      <= '0;
                  exec_valid <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE, S_WAIT: begin
               count <= count + 1'b1;
               if (finish) begin
                  exec_valid <= 1'b0;
                  state      <= S_COMPLETE;
                  // Only the requester that owns this command sees its result.
                  if (exec_src == SRC_HOST) begin
                     host_done    <= 1'b1;
                     host_error   <= fin_error;
                     host_result0 <= fin_result0;
                     host_result1 <= fin_result1;
                  end else begin
                     n64_done     <= 1'b1;
                     n64_error    <= fin_error;
                     n64_result0  <= fin_result0;
                     n64_result1  <= fin_result1;
                  end
               end else if ((state == S_ISSUE) && exec_ready) begin
                  exec_valid <= 1'b0;
                  state      <= S_WAIT;
               end
            end
            S_COMPLETE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/cfg_cmd_scheduler.md
Name: cfg_cmd_scheduler

Overview:
Shares one command executor (the MCU-side command handler) between two requesters: the N64 config command path (pending/cmd/data words) and the host/USB command path. The block arbitrates round-robin, latches the granted command and arguments, and issues it with a valid/ready handshake. It then waits for completion under a timeout and returns the done, error and result words to the originating requester. It sits between the N64 config register block and the executor in the fw RTL top level.

Parameters:
TIMEOUT_CYCLES, 1000000, clk cycles allowed from grant to exec_done before forced error completion (must be >= 2)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
n64_pending  input  1  N64 command pending (level; cleared by requester one cycle after n64_done)
n64_cmd  input  8  N64 command id
n64_arg0  input  32  N64 argument word 0
n64_arg1  input  32  N64 argument word 1
n64_done  output  1  one-cycle completion pulse to N64 path
n64_error  output  1  error flag for last N64 command (held)
n64_result0  output  32  result word 0 for N64 (held)
n64_result1  output  32  result word 1 for N64 (held)
host_valid  input  1  host command request; held with args until host_ready
host_cmd  input  8  host command id
host_arg0  input  32  host argument word 0
host_arg1  input  32  host argument word 1
host_ready  output  1  one-cycle accept pulse (grant)
host_done  output  1  one-cycle completion pulse to host
host_error  output  1  error flag for last host command (held)
host_result0  output  32  result word 0 for host (held)
host_result1  output  32  result word 1 for host (held)
exec_valid  output  1  command presented to executor
exec_src  output  1  0 = N64, 1 = host
exec_cmd  output  8  latched command id
exec_arg0  output  32  latched argument word 0
exec_arg1  output  32  latched argument word 1
exec_ready  input  1  executor accepts (transfer when exec_valid & exec_ready)
exec_done  input  1  executor completion pulse
exec_error  input  1  executor error, valid with exec_done
exec_result0  input  32  result word 0, valid with exec_done
exec_result1  input  32  result word 1, valid with exec_done
exec_abort  output  1  one-cycle pulse on timeout
busy  output  1  high in any state except IDLE

Behaviour:
- Reset: state IDLE; all pulses, exec_valid, busy, errors = 0; results = 0; exec_src/cmd/args = 0; last_grant = host (so N64 wins the first tie); timeout counter = 0.
- States: IDLE, ISSUE, WAIT, COMPLETE.
- IDLE: requests are n64_pending and host_valid. If only one is high, grant it. If both are high, grant the one not equal to last_grant. On grant: latch src/cmd/args into exec_*, update last_grant, clear counter, go to ISSUE. Host grant pulses host_ready in this same cycle. An N64 grant has no ack.
- ISSUE: exec_valid = 1 and exec_* stable. When exec_ready is high, go to WAIT (exec_valid drops the next cycle).
- WAIT: exec_done high -> capture exec_error/result into the src requester's error/result registers, go to COMPLETE.
- Timeout: counter increments every cycle in ISSUE and WAIT. When it reaches TIMEOUT_CYCLES-1 with no exec_done that cycle: pulse exec_abort, set src error = 1, results = 0, go to COMPLETE. If exec_done arrives in the same cycle as expiry, exec_done wins and there is no abort. Timeout from ISSUE also drops exec_valid.
- COMPLETE (exactly 1 cycle): pulse n64_done or host_done per src, then return to IDLE. The N64 path clears n64_pending on this edge, so the pending seen in IDLE is a new request and never a re-grant.
- exec_done outside WAIT is ignored. exec_ready outside ISSUE is ignored.
- Result/error registers of the non-served requester are untouched.
- Grant-to-issue latency: exec_valid high 1 cycle after grant. exec_done -> *_done: 1 cycle.
- host_valid dropping before grant: no grant. After grant, host_valid is don't-care until the next IDLE.
- Reset mid-operation: immediate return to IDLE, no done/abort pulses, outputs at reset values.

Test Plan:
- N64 only: n64_pending=1, cmd=0x10, arg0=0x11223344; exec_ready same cycle exec_valid rises; exec_done 5 cycles later with result0=0xCAFEF00D, error=0 -> exec_cmd=0x10, exec_src=0, n64_done 1 pulse, n64_result0=0xCAFEF00D, n64_error=0, host outputs unchanged.
- Simultaneous: n64_pending and host_valid high from reset, executor completes each in 3 cycles -> order N64, host, N64, host. host_ready pulses only on host grants. No back-to-back double N64 grant.
- Backpressure: exec_ready held low 20 cycles -> exec_valid and exec_cmd/args stable all 20 cycles, then WAIT entered on the ready cycle.
- Timeout with TIMEOUT_CYCLES=16, host cmd 0x22, no exec_done -> exec_abort pulse 16 cycles after grant cycle, host_done next cycle, host_error=1, host_result0/1=0, then IDLE.
- Race: exec_done asserted in the exact expiry cycle with result0=5 -> no exec_abort, host_error=exec_error, host_result0=5.
- Reset asserted in WAIT -> next cycle busy=0, exec_valid=0, no done pulse. A new n64_pending is then granted normally.
